cpu_lr_stack: RTL and testbench

Link-register return-address stack feeding the jump unit's `LR_ADDRESS` input. On a call it captures the return address, `PC_IN + 1`; on a return it pops that address so the next return sees the previous caller. It is a circular buffer of `DEPTH` entries with an overflow/underflow policy, between the instruction decoder (PUSH/POP) and `cpu_jmp` (`LR_ADDRESS`).

---
 rtl/cpu_lr_stack_pkg.sv | 36 +++
 rtl/cpu_lr_mem.sv | 24 ++
 rtl/cpu_lr_stack.sv | 114 +++++++++++
 tb/tb_cpu_lr_stack.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_lr_stack_pkg.sv
// Shared definitions for the link-register return stack: jump-mode encodings,
// default address width and the per-edge action decode.
package cpu_lr_stack_pkg;

    localparam int LR_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        JMP_ABS  = 2'b00,
        JMP_BASE = 2'b01,
        JMP_CALL = 2'b10,
        JMP_RET  = 2'b11
    } jmp_mode_e;

    typedef enum logic [2:0] {
        LR_IDLE,
        LR_FLUSH,
        LR_REPLACE,
        LR_PUSH,
        LR_POP,
        LR_UNDERFLOW
    } lr_op_e;

    // PUSH+POP on an empty stack collapses to a plain push, so no underflow.
    function automatic lr_op_e lr_decode(input logic flush, input logic push,
                                         input logic pop, input logic empty);
        lr_op_e op;
        if (flush)                   op = LR_FLUSH;
        else if (push && pop && !empty) op = LR_REPLACE;
        else if (push)               op = LR_PUSH;
        else if (pop && empty)       op = LR_UNDERFLOW;
        else if (pop)                op = LR_POP;
        else                         op = LR_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/cpu_lr_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one async read port.
// Contents are intentionally not reset; the stack masks them with EMPTY.
module cpu_lr_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) mem_q[WADDR] <= WDATA;
    end

    assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/cpu_lr_stack.sv
// Circular return-address stack feeding the jump unit's LR_ADDRESS.
// Push stores PC_IN+1; overflow overwrites the oldest entry, underflow is a no-op.
module cpu_lr_stack
    import cpu_lr_stack_pkg::*;
#(
    parameter int WIDTH = LR_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic                     FLUSH,
    input  logic [WIDTH-1:0]         PC_IN,
    output logic [WIDTH-1:0]         LR_ADDRESS,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]    TOP_ONE = AW'(1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);
    localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);

    logic [AW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             empty, full;
    lr_op_e           op;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);
    assign wdata = PC_IN + PC_ONE;
    assign op    = lr_decode(FLUSH, PUSH, POP, empty);

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = top_q;
        case (op)
            LR_FLUSH: begin
                top_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            LR_REPLACE: begin
                we    = 1'b1;
                waddr = top_q;
            end
            LR_PUSH: begin
                // Pointer advances even when full so the oldest entry is lost.
                top_d = top_q + TOP_ONE;
                we    = 1'b1;
                waddr = top_q + TOP_ONE;
                if (full) ovf_d   = 1'b1;
                else      count_d = count_q + CNT_ONE;
            end
            LR_POP: begin
                top_d   = top_q - TOP_ONE;
                count_d = count_q - CNT_ONE;
            end
            LR_UNDERFLOW: unf_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    cpu_lr_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .WE    (we),
        .WADDR (waddr),
        .WDATA (wdata),
        .RADDR (top_q),
        .RDATA (rdata)
    );

    assign LR_ADDRESS = empty ? '0 : rdata;
    assign COUNT      = count_q;
    assign EMPTY      = empty;
    assign FULL       = full;
    assign OVF        = ovf_q;
    assign UNF        = unf_q;

endmodule

// File: tb/tb_cpu_lr_stack.sv
// Directed bench for cpu_lr_stack: reset, LIFO order, overflow wrap,
// underflow, simultaneous push/pop, address wrap and flush priority.
module tb_cpu_lr_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             PUSH = 1'b0;
    logic             POP = 1'b0;
    logic             FLUSH = 1'b0;
    logic [WIDTH-1:0] PC_IN = '0;
    logic [WIDTH-1:0] LR_ADDRESS;
    logic [2:0]       COUNT;
    logic             EMPTY, FULL, OVF, UNF;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    cpu_lr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PUSH       (PUSH),
        .POP        (POP),
        .FLUSH      (FLUSH),
        .PC_IN      (PC_IN),
        .LR_ADDRESS (LR_ADDRESS),
        .COUNT      (COUNT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .OVF        (OVF),
        .UNF        (UNF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock of strobes; returns 1 time unit after the capturing edge.
    task automatic cyc(input logic push, input logic pop, input logic flush,
                       input logic [WIDTH-1:0] pc);
        PUSH = push; POP = pop; FLUSH = flush; PC_IN = pc;
        @(posedge CLK);
        #1;
        PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0; PC_IN = '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] pc); cyc(1'b1, 1'b0, 1'b0, pc); endtask
    task automatic pop();                           cyc(1'b0, 1'b1, 1'b0, 8'h00); endtask
    task automatic flush();                         cyc(1'b0, 1'b0, 1'b1, 8'h00); endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge CLK);
        #1;
        chk("por_lr",    LR_ADDRESS, 8'h00);
        chk("por_count", COUNT, 0);
        chk("por_empty", EMPTY, 1);
        chk("por_full",  FULL, 0);
        chk("por_ovf",   OVF, 0);
        chk("por_unf",   UNF, 0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        // Mid-cycle asynchronous reset discards entries immediately
        push(8'h30);
        chk("pre_rst_lr",    LR_ADDRESS, 8'h31);
        chk("pre_rst_count", COUNT, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_lr",    LR_ADDRESS, 8'h00);
        chk("async_rst_empty", EMPTY, 1);
        chk("async_rst_count", COUNT, 0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        // LIFO order
        push(8'h10); push(8'h20); push(8'h68);
        chk("lifo_top",   LR_ADDRESS, 8'h69);
        chk("lifo_count", COUNT, 3);
        pop();
        chk("lifo_pop1", LR_ADDRESS, 8'h21);
        pop();
        chk("lifo_pop2", LR_ADDRESS, 8'h11);
        pop();
        chk("lifo_pop3",   LR_ADDRESS, 8'h00);
        chk("lifo_empty",  EMPTY, 1);
        chk("lifo_unf",    UNF, 0);

        // Overflow wrap: 01 is overwritten by 05
        push(8'h00); push(8'h01); push(8'h02); push(8'h03);
        chk("ovf_full4", FULL, 1);
        chk("ovf_pre",   OVF, 0);
        push(8'h04);
        chk("ovf_full",  FULL, 1);
        chk("ovf_set",   OVF, 1);
        chk("ovf_count", COUNT, 4);
        chk("ovf_pop1",  LR_ADDRESS, 8'h05); pop();
        chk("ovf_pop2",  LR_ADDRESS, 8'h04); pop();
        chk("ovf_pop3",  LR_ADDRESS, 8'h03); pop();
        chk("ovf_pop4",  LR_ADDRESS, 8'h02); pop();
        chk("ovf_empty", EMPTY, 1);
        chk("ovf_lr0",   LR_ADDRESS, 8'h00);
        chk("ovf_sticky", OVF, 1);
        flush();
        chk("ovf_clr",   OVF, 0);

        // Underflow
        pop();
        chk("unf_set",   UNF, 1);
        chk("unf_count", COUNT, 0);
        chk("unf_lr",    LR_ADDRESS, 8'h00);
        flush();
        chk("unf_clr",   UNF, 0);

        // Simultaneous push and pop
        push(8'h10); push(8'h10);
        chk("pp_setup", LR_ADDRESS, 8'h11);
        cyc(1'b1, 1'b1, 1'b0, 8'h40);
        chk("pp_lr",    LR_ADDRESS, 8'h41);
        chk("pp_count", COUNT, 2);
        pop();
        chk("pp_below", LR_ADDRESS, 8'h11);
        flush();
        cyc(1'b1, 1'b1, 1'b0, 8'h40);
        chk("ppe_count", COUNT, 1);
        chk("ppe_unf",   UNF, 0);
        chk("ppe_lr",    LR_ADDRESS, 8'h41);

        // Address wrap and flush priority
        flush();
        push(8'hFF);
        chk("wrap_lr",    LR_ADDRESS, 8'h00);
        chk("wrap_empty", EMPTY, 0);
        chk("wrap_count", COUNT, 1);
        cyc(1'b1, 1'b0, 1'b1, 8'h05);
        chk("fp_count", COUNT, 0);
        chk("fp_empty", EMPTY, 1);
        chk("fp_lr",    LR_ADDRESS, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
